muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide instructions; sits beside the single-cycle integer ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake.
- Runs a shift-add multiplier or restoring divider for a fixed number of iterations, then applies sign correction.
- Holds the 32-bit result until the pipeline consumes it.

Parameters:
- BITS_PER_CYCLE, 1: result bits retired per iteration cycle. Legal values are 1, 2 and 4. ITERS = 32/BITS_PER_CYCLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  operation request.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  input  32  rs1 operand.
- req_b  input  32  rs2 operand.
- kill  input  1  pipeline flush; abort the current operation.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0, iteration counter=0. Reset mid-operation discards all work.
- req_ready=1 only in IDLE. A request is accepted on an edge where req_valid && req_ready. Operands and op are latched at that edge, and later changes on the req_* inputs are ignored.
- Operand prep at accept:
  - Magnitudes are taken per signedness. MULH: both signed. MULHSU: a signed, b unsigned. DIV/REM: both signed. MULHU/DIVU/REMU/MUL: unsigned.
  - Result sign is recorded: product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
- Special cases, decided at accept, go directly to DONE with no iterations:
  - DIV/DIVU with b=0: result 0xFFFFFFFF.
  - REM/REMU with b=0: result = a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- MUL state:
  - 64-bit accumulator; BITS_PER_CYCLE multiplier bits are consumed per cycle, for ITERS cycles.
  - MUL returns the low 32 bits of the product; the MULH variants return the high 32 bits after sign correction.
- DIV state:
  - Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle, for ITERS cycles.
  - The 33-bit partial remainder subtract sets a quotient bit when the result is non-negative.
- FIX (1 cycle): the recorded sign is applied by two's-complement negation of the 64-bit product, the quotient or the remainder. resp_data is loaded, then the state goes to DONE.
- Latency, normal op: accept edge T, resp_valid rises at edge T+ITERS+2. With BITS_PER_CYCLE=1 that is T+34.
- Latency, special case: resp_valid rises at edge T+1.
- DONE:
  - resp_valid=1, and resp_data is held stable until resp_valid && resp_ready.
  - On that edge the state goes to IDLE and resp_valid goes to 0.
  - A new request can be accepted no earlier than the following edge; there is no same-cycle turnaround.
- kill:
  - In MUL, DIV, FIX or DONE: the next edge forces IDLE, resp_valid=0, and no response is produced.
  - In IDLE: kill beats req_valid, so no accept occurs.
  - kill in the same cycle as resp_ready in DONE behaves as kill.
- The iteration counter counts ITERS-1 down to 0; the last iteration moves the state to FIX.
- resp_data keeps its last value when not valid. Consumers must not rely on it in that case.

Test Plan:
- MULH a=0xFFFFFFFE (-2), b=0x00000003, BITS_PER_CYCLE=1 -> resp_valid at T+34, resp_data=0xFFFFFFFF. Repeating with MUL gives 0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REMU a=7, b=2 -> 1.
- DIVU a=5, b=0 -> 0xFFFFFFFF at T+1. REM a=0x12345678, b=0 -> 0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- MULHSU a=0x80000000, b=0xFFFFFFFF -> 0x80000000. MULHU with the same operands -> 0x7FFFFFFF.
- Back-pressure: hold resp_ready=0 for 10 cycles after resp_valid -> resp_data stable and req_ready=0 throughout. Then resp_ready=1 -> IDLE next edge, and a new request is accepted on the edge after that.
- kill asserted at iteration 10 of a DIV -> IDLE next edge with no resp_valid; an immediate new MUL 6*7 -> 42. Also assert rst_n=0 mid-MUL -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    // Pipeline side: issues operations and consumes results.
    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply or restoring divide on
// operand magnitudes, followed by one sign-correction cycle. Result is held until consumed.
module muldiv_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);
    localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e      r_state, w_state_next;
    logic [5:0]  r_cnt, w_cnt_next;
    logic [63:0] r_acc, w_acc_next;
    logic [31:0] r_opb, w_opb_next;
    logic [2:0]  r_op, w_op_next;
    logic        r_neg, w_neg_next;
    logic        r_resp_valid, w_resp_valid_next;
    logic [31:0] r_resp_data, w_resp_data_next;

    logic        w_accept, w_signed_a, w_signed_b, w_sa, w_sb;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div_zero, w_div_ovf, w_special;
    logic [31:0] w_special_res;
    logic [63:0] w_mul_acc, w_div_acc, w_prod;
    logic [31:0] w_quot, w_rem, w_fix_res;

    // Kill in IDLE wins over an incoming request.
    assign w_accept   = bus.req_valid && (r_state == StIdle) && !bus.kill;
    assign w_signed_a = (bus.req_op == 3'b001) || (bus.req_op == 3'b010) ||
                        (bus.req_op == 3'b100) || (bus.req_op == 3'b110);
    assign w_signed_b = (bus.req_op == 3'b001) || (bus.req_op == 3'b100) ||
                        (bus.req_op == 3'b110);
    assign w_sa       = w_signed_a && bus.req_a[31];
    assign w_sb       = w_signed_b && bus.req_b[31];
    assign w_mag_a    = w_sa ? (32'd0 - bus.req_a) : bus.req_a;
    assign w_mag_b    = w_sb ? (32'd0 - bus.req_b) : bus.req_b;

    // Divide-by-zero and signed overflow bypass the iterations entirely.
    assign w_div_zero = bus.req_op[2] && (bus.req_b == 32'd0);
    assign w_div_ovf  = bus.req_op[2] && !bus.req_op[0] &&
                        (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF)
                                      : (bus.req_op[1] ? 32'd0 : 32'h8000_0000);

    // Shift-add multiply step: acc = {partial product hi, remaining multiplier bits}.
    always_comb begin : mul_step
        logic [63:0] v;
        logic [32:0] s;
        v = r_acc;
        s = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            s = {1'b0, v[63:32]} + {1'b0, r_opb};
            if (v[0]) v = {s, v[31:1]};
            else      v = {1'b0, v[63:1]};
        end
        w_mul_acc = v;
    end

    // Restoring divide step: acc = {partial remainder, dividend/quotient shift register}.
    always_comb begin : div_step
        logic [63:0] d;
        logic [32:0] pr;
        d  = r_acc;
        pr = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            pr = d[63:31];
            // Subtract is non-negative exactly when the 33-bit remainder >= divisor.
            if (pr >= {1'b0, r_opb}) d = {d[62:31] - r_opb, d[30:0], 1'b1};
            else                     d = {d[62:0], 1'b0};
        end
        w_div_acc = d;
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        w_prod = r_neg ? (64'd0 - r_acc) : r_acc;
        w_quot = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        case (r_op)
            3'b000:                 w_fix_res = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[63:32];
            3'b100, 3'b101:         w_fix_res = w_quot;
            default:                w_fix_res = w_rem;
        endcase
    end

    // Next-state and datapath update; kill from any busy state overrides everything.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_acc_next        = r_acc;
        w_opb_next        = r_opb;
        w_op_next         = r_op;
        w_neg_next        = r_neg;
        w_resp_valid_next = r_resp_valid;
        w_resp_data_next  = r_resp_data;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_op_next  = bus.req_op;
                    w_acc_next = {32'd0, w_mag_a};
                    w_opb_next = w_mag_b;
                    // Remainder takes the dividend's sign; everything else sa^sb.
                    w_neg_next = (bus.req_op[2] && bus.req_op[1]) ? w_sa : (w_sa ^ w_sb);
                    if (w_special) begin
                        w_resp_data_next = w_special_res;
                        w_state_next     = StDone;
                    end else begin
                        w_cnt_next   = 6'(ITERS - 1);
                        w_state_next = bus.req_op[2] ? StDiv : StMul;
                    end
                end
            end
            StMul, StDiv: begin
                w_acc_next = (r_state == StMul) ? w_mul_acc : w_div_acc;
                if (r_cnt == 6'd0) w_state_next = StFix;
                else               w_cnt_next   = r_cnt - 6'd1;
            end
            StFix: begin
                w_resp_data_next = w_fix_res;
                w_state_next     = StDone;
            end
            StDone: begin
                // resp_valid is registered, so it rises one edge after entering DONE.
                if (r_resp_valid && bus.resp_ready) begin
                    w_resp_valid_next = 1'b0;
                    w_state_next      = StIdle;
                end else begin
                    w_resp_valid_next = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (bus.kill && (r_state != StIdle)) begin
            w_state_next      = StIdle;
            w_resp_valid_next = 1'b0;
            w_cnt_next        = 6'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 6'd0;
            r_acc        <= 64'd0;
            r_opb        <= 32'd0;
            r_op         <= 3'd0;
            r_neg        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_acc        <= w_acc_next;
            r_opb        <= w_opb_next;
            r_op         <= w_op_next;
            r_neg        <= w_neg_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_data  <= w_resp_data_next;
        end
    end

    assign bus.req_ready  = (r_state == StIdle);
    assign bus.busy       = (r_state != StIdle);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M vectors, arithmetic reference model, cycle compare.
module tb_muldiv_seq;
    localparam int unsigned BPC   = 1;
    localparam int unsigned ITERS = 32 / BPC;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    muldiv_seq_if bus ();

    muldiv_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 0;
        case (op)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Protocol-level model: idle/busy, cycles until the response, expected data.
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_wait  <= 0;
        end else if (m_idle) begin
            if (bus.req_valid && !bus.kill) begin
                m_idle <= 1'b0;
                m_pend <= ref_result(bus.req_op, bus.req_a, bus.req_b);
                m_wait <= is_special(bus.req_op, bus.req_a, bus.req_b) ? 1 : int'(ITERS) + 2;
            end
        end else if (bus.kill) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (bus.resp_ready) begin
                m_idle  <= 1'b1;
                m_valid <= 1'b0;
            end
        end else begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_data  <= m_pend;
            end
        end
    end

    // Every-cycle compare against the model on the inactive edge.
    always @(negedge clk) begin
        check("cyc_req_ready", {31'd0, bus.req_ready}, {31'd0, m_idle});
        check("cyc_busy", {31'd0, bus.busy}, {31'd0, !m_idle});
        check("cyc_resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_valid});
        if (m_valid) check("cyc_resp_data", bus.resp_data, m_data);
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        // Scramble the request lines: the unit must use its latched copies.
        bus.req_valid = 1'b0;
        bus.req_op    = ~op;
        bus.req_a     = ~a;
        bus.req_b     = b ^ 32'h5A5A_A5A5;
    endtask

    task automatic wait_valid(input string name, input int exp_lat, input logic [31:0] exp);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.resp_valid) seen = 1'b1;
        end
        check({name, "_lat"}, n, exp_lat);
        check(name, bus.resp_data, exp);
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("idle_after_resp", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        start_op(op, a, b);
        wait_valid(name, exp_lat, exp);
        consume();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_resp_data"}, bus.resp_data, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int nl;
        nl = int'(ITERS) + 2;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mulh_neg2x3", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34);
        do_op("mul_neg2x3", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, nl);
        do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, nl);
        do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, nl);
        do_op("remu_7_2", 3'b111, 32'd7, 32'd2, 32'd1, nl);
        do_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_by0", 3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("mulhsu_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, nl);
        do_op("mulhu_min", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, nl);
        do_op("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, nl);
        do_op("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, nl);
        do_op("mul_m1_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, nl);
        do_op("mulh_m1_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, nl);
        do_op("divu_max_3", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, nl);

        // Back-pressure: result and req_ready must hold while the consumer stalls.
        start_op(3'b011, 32'h0001_0000, 32'h0001_0000);
        wait_valid("bp_mulhu", nl, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", bus.resp_data, 32'd1);
            check("bp_hold_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("bp_idle", {31'd0, bus.req_ready}, 32'd1);
        check("bp_valid_low", {31'd0, bus.resp_valid}, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("bp_next_accept", {31'd0, bus.busy}, 32'd1);
        wait_valid("bp_next_mul", nl, 32'd99);
        consume();

        // Kill part-way through a divide, then an immediate multiply.
        start_op(3'b100, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        check("kill_div_busy", {31'd0, bus.busy}, 32'd0);
        check("kill_div_valid", {31'd0, bus.resp_valid}, 32'd0);
        do_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, nl);

        // Kill in IDLE blocks an accept.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.kill      = 1'b1;
        bus.req_op    = 3'b000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        check("kill_idle_no_accept", {31'd0, bus.busy}, 32'd0);

        // Kill together with resp_ready in DONE drops the response.
        start_op(3'b101, 32'd50, 32'd5);
        wait_valid("divu_50_5", nl, 32'd10);
        bus.kill       = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;
        check("kill_done_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("kill_done_busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-multiply, between clock edges.
        start_op(3'b000, 32'd123, 32'd456);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("mul_after_rst", 3'b000, 32'd123, 32'd456, 32'd56088, nl);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
